// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
package period_meter_pkg;

  localparam int CNT_W_DEF       = 28;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DGL_CYC_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TMO
  } state_e;

endpackage

// File: rtl/period_meter_sig_sync.sv
// Synchronizer, optional deglitch filter (PERIOD_METER_DEGLITCH_EN) and rise detector.
// rise_o lags sig_i by SYNC_STAGES+1 cycles (+DGL_CYC with the filter); no backpressure.
module sig_sync
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DGL_CYC     = DGL_CYC_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   filt;
  logic                   lvl_q;
  logic                   rise_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PERIOD_METER_DEGLITCH_EN
  localparam int DW = $clog2(DGL_CYC + 1);

  logic [DW-1:0] dgl_q;
  logic          filt_q;

  // Counter runs only while the input disagrees with the filtered level;
  // any return to agreement restarts the qualification window.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dgl_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_lvl == filt_q) begin
      dgl_q <= '0;
    end else if (dgl_q == DW'(DGL_CYC - 1)) begin
      dgl_q  <= '0;
      filt_q <= sync_lvl;
    end else begin
      dgl_q <= dgl_q + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_lvl;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      lvl_q  <= filt;
      rise_q <= filt & ~lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an async square wave in sys_clk cycles; results one cycle after a rise.
// Optional deglitch via PERIOD_METER_DEGLITCH_EN; no backpressure, valid_o is a single-cycle pulse.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DGL_CYC     = DGL_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  logic level;
  logic rise;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;

  sig_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DGL_CYC    (DGL_CYC)
  ) u_sig_sync (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .sig_i  (sig_i),
    .level_o(level),
    .rise_o (rise)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE, TMO: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
        end
      end
      MEASURE: begin
        // A rise wins over an expiring counter: the all-ones count is a valid period.
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          tmo_d    = 1'b0;
          cnt_d    = CNT_W'(1);
          hcnt_d   = CNT_W'(1);
        end else if (cnt_q == '1) begin
          state_d = TMO;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (level && hcnt_q != '1) begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: an 8-bit instance for waveform tests, a 6-bit one for timeout.
module tb_period_meter;

`ifdef PERIOD_METER_DEGLITCH_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       sig8 = 1'b0;
  logic       sig6 = 1'b0;
  logic [7:0] per8, high8;
  logic       valid8, tmo8;
  logic [5:0] per6, high6;
  logic       valid6, tmo6;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int v6_cnt = 0;
  int q_per[$];
  int q_high[$];
  int q_cyc[$];

  always #5 sys_clk = ~sys_clk;

  period_meter #(.CNT_W(8)) dut8 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .sig_i    (sig8),
    .period_o (per8),
    .high_o   (high8),
    .valid_o  (valid8),
    .timeout_o(tmo8)
  );

  period_meter #(.CNT_W(6)) dut6 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .sig_i    (sig6),
    .period_o (per6),
    .high_o   (high6),
    .valid_o  (valid6),
    .timeout_o(tmo6)
  );

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (valid8 === 1'b1) begin
      q_per.push_back(int'(per8));
      q_high.push_back(int'(high8));
      q_cyc.push_back(cyc);
    end
    if (valid6 === 1'b1) v6_cnt <= v6_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wave8(input int hi, input int lo, input int n);
    repeat (n) begin
      sig8 = 1'b1;
      repeat (hi) tick();
      sig8 = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic clear_q();
    q_per.delete();
    q_high.delete();
    q_cyc.delete();
  endtask

  // First captured entry may carry the tail of the previous waveform.
  task automatic expect_q(input string tag, input int n, input int p0, input int h0,
                          input int p, input int h);
    chk({tag, "_cnt"}, q_per.size(), n);
    for (int i = 0; i < q_per.size(); i++) begin
      chk({tag, "_per"}, q_per[i], (i == 0) ? p0 : p);
      chk({tag, "_high"}, q_high[i], (i == 0) ? h0 : h);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_per8", per8, 0);
    chk("rst_high8", high8, 0);
    chk("rst_valid8", valid8, 0);
    chk("rst_tmo8", tmo8, 0);
    chk("rst_per6", per6, 0);
    chk("rst_valid6", valid6, 0);
    chk("rst_tmo6", tmo6, 0);
    sys_rst = 1'b0;
    repeat (2) tick();

    // 8/8 steady wave: five rises give four results
    clear_q();
    wave8(8, 8, 5);
    expect_q("w8x8", 4, 16, 8, 16, 8);
    for (int i = 1; i < q_cyc.size(); i++) chk("w8x8_gap", q_cyc[i] - q_cyc[i-1], 16);

    // 3/13 then 5/5
    clear_q();
    wave8(3, 13, 3);
    expect_q("w3x13", 3, 16, 8, 16, 3);
    clear_q();
    wave8(5, 5, 3);
    expect_q("w5x5", 3, 16, 3, 10, 5);

    // 6-bit timeout, then recovery over two rises
    sig6 = 1'b1;
    repeat (6) tick();
    sig6 = 1'b0;
    repeat (LAT + 63 - 6) tick();
    chk("tmo_before", tmo6, 0);
    tick();
    chk("tmo_set", tmo6, 1);
    chk("tmo_novalid", v6_cnt, 0);
    sig6 = 1'b1;
    repeat (6) tick();
    sig6 = 1'b0;
    repeat (14) tick();
    chk("tmo_arm_held", tmo6, 1);
    chk("tmo_arm_novalid", v6_cnt, 0);
    sig6 = 1'b1;
    repeat (LAT) tick();
    chk("tmo_pre_valid", valid6, 0);
    chk("tmo_pre_tmo", tmo6, 1);
    tick();
    chk("tmo_valid", valid6, 1);
    chk("tmo_per", per6, 20);
    chk("tmo_high", high6, 6);
    chk("tmo_clear", tmo6, 0);
    tick();
    chk("tmo_pulse", valid6, 0);
    sig6 = 1'b0;

    // reset mid-period discards the partial measurement
    sig8 = 1'b1;
    repeat (6) tick();
    sys_rst = 1'b1;
    sig8 = 1'b0;
    tick();
    chk("mid_rst_per", per8, 0);
    chk("mid_rst_high", high8, 0);
    chk("mid_rst_valid", valid8, 0);
    chk("mid_rst_tmo", tmo8, 0);
    tick();
    sys_rst = 1'b0;
    repeat (3) tick();
    clear_q();
    wave8(6, 10, 2);
    expect_q("post_rst", 1, 16, 6, 16, 6);

    // 20/20 wave with 2-cycle glitches in both halves
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    repeat (3) tick();
    clear_q();
    repeat (4) begin
      sig8 = 1'b1; repeat (8) tick();
      sig8 = 1'b0; repeat (2) tick();
      sig8 = 1'b1; repeat (10) tick();
      sig8 = 1'b0; repeat (9) tick();
      sig8 = 1'b1; repeat (2) tick();
      sig8 = 1'b0; repeat (9) tick();
    end
`ifdef PERIOD_METER_DEGLITCH_EN
    expect_q("glitch", 3, 40, 20, 40, 20);
`else
    chk("glitch_cnt", q_per.size(), 11);
    if (q_per.size() > 0) begin
      chk("glitch_per0", q_per[0], 10);
      chk("glitch_high0", q_high[0], 8);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 28, width of the cycle counter and of the period and high-time outputs.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_i (minimum 2).
REQ-003 Parameter DGL_CYC, default 4, number of stable cycles the deglitch filter requires.
REQ-004 Port sys_clk, input, 1 bit, the single clock.
REQ-005 Port sys_rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 Port sig_i, input, 1 bit, asynchronous square wave to measure (e.g. a blink output).
REQ-007 Port period_o, output, CNT_W bits, sys_clk cycles between the last two rising edges.
REQ-008 Port high_o, output, CNT_W bits, sys_clk cycles sig_i was high within that period.
REQ-009 Port valid_o, output, 1 bit, one-cycle pulse when period_o and high_o update.
REQ-010 Port timeout_o, output, 1 bit, level indicating no rising edge within 2^CNT_W-1 cycles.

Function
REQ-011 The block SHALL pass sig_i through SYNC_STAGES flops and then an edge-detect flop; a detected edge lags sig_i by SYNC_STAGES+1 cycles.
REQ-012 The state machine SHALL have three states: IDLE (wait for the first rise), MEASURE (counting), and TMO (timed out, waiting for a rise).
REQ-013 IDLE or TMO on rise -> MEASURE, with cnt<=1 and hcnt<=1 and no valid_o pulse.
REQ-014 In MEASURE, cnt SHALL increment every cycle, and hcnt SHALL increment on every cycle the synchronized level is high.
REQ-015 MEASURE on rise SHALL set period_o<=cnt, high_o<=hcnt, valid_o=1 on the next cycle, then cnt<=1 and hcnt<=1.
REQ-016 The captured period SHALL equal exactly the sys_clk cycle count between consecutive detected rising edges.
REQ-017 MEASURE with cnt equal to all-ones and no rise SHALL go to TMO with timeout_o<=1, and period_o and high_o held.
REQ-018 timeout_o SHALL clear on the cycle of the next valid_o pulse.
REQ-019 A rise coinciding with cnt all-ones SHALL be treated as a rise: capture, no timeout.
REQ-020 hcnt SHALL saturate and never wrap, being bounded by cnt.
REQ-021 period_o and high_o SHALL change only together with a valid_o pulse.

Reset
REQ-022 sys_rst SHALL be sampled on sys_clk only and take effect on the next edge.
REQ-023 Reset SHALL produce: state IDLE, cnt=0, hcnt=0, period_o=0, high_o=0, valid_o=0, timeout_o=0, synchronizer flops=0, deglitch counter=0.
REQ-024 Reset asserted mid-measurement SHALL discard the partial count, and the first rise after release SHALL only arm the measurement (no valid_o).

Configuration
REQ-025 Macro PERIOD_METER_DEGLITCH_EN, when defined, SHALL insert a filter after the synchronizer that updates the filtered level only after DGL_CYC consecutive identical samples, adding DGL_CYC cycles of latency.
REQ-026 Without PERIOD_METER_DEGLITCH_EN, the filtered level SHALL equal the synchronizer output, and DGL_CYC SHALL be ignored.

Structure
REQ-027 Package period_meter_pkg SHALL hold the state enum (IDLE, MEASURE, TMO) and the default constants for CNT_W, SYNC_STAGES and DGL_CYC.
REQ-028 Sub-module sig_sync SHALL contain the synchronizer, the optional deglitch filter and the edge detector, and output level and rise.
REQ-029 period_meter SHALL contain the FSM, the counters and the output registers.

Verification
REQ-030 Square wave of 8 high / 8 low, CNT_W=8, steady state -> valid_o every 16 cycles with period_o=16 and high_o=8; the first edge produces no valid_o.
REQ-031 Square wave of 3 high / 13 low -> period_o=16, high_o=3; changing to 5/5 -> the next valid_o reports 10/5.
REQ-032 CNT_W=6 with sig_i held low after one rise -> timeout_o=1 at 63 cycles after the rise and valid_o stays 0; the next two rises -> timeout_o clears with the valid_o carrying the new period.
REQ-033 sys_rst pulsed mid-period -> all outputs 0, and the first post-reset rise gives no valid_o, the second gives a correct period.
REQ-034 With PERIOD_METER_DEGLITCH_EN and DGL_CYC=4, 2-cycle glitches on a 20/20 wave -> period_o=40, high_o=20, no spurious valid_o; without the macro, the same stimulus produces extra valid_o pulses.
